board_mem_rw: RTL and testbench

BOARD_MEM_RW -- requirements
Module: board_mem_rw

---
 rtl/board_mem_rw.sv | 192 +++++++++++++++++++
 tb/tb_board_mem_rw.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/board_mem_rw.sv
// board_mem_rw: register-based game board with one write port, one read port,
// a row-at-a-time clear sweep and a live count of occupied cells.
//
// Optional feature macro: BOARD_MEM_OCCUPY_CHECK_EN
//   defined   -> a nonzero write onto a nonzero cell is rejected (wr_err)
//   undefined -> such a write overwrites the cell (wr_ack, count unchanged)
//
// Ports
//   clock, reset     : sole clock, synchronous active-high reset
//   wr_en/addr/data  : write request, addr = {x,y}, each XY_W bits
//   wr_ack / wr_err  : one-cycle pulse the cycle after a write is sampled
//   rd_en/addr       : read request, addr = {x,y}
//   rd_data/rd_valid : registered read result (latency 1), held when not valid
//   clear_req / busy : start clear sweep / sweep running
//   stone_count      : number of nonzero cells
//   board_out        : flattened cells, (x,y) at [(x*BOARD_DIM+y)*CELL_W +: CELL_W]
module board_mem_rw #(
  parameter int BOARD_DIM = 16,
  parameter int XY_W      = 4,
  parameter int CELL_W    = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  wr_en,
  input  logic [2*XY_W-1:0]                     wr_addr,
  input  logic [CELL_W-1:0]                     wr_data,
  output logic                                  wr_ack,
  output logic                                  wr_err,
  input  logic                                  rd_en,
  input  logic [2*XY_W-1:0]                     rd_addr,
  output logic [CELL_W-1:0]                     rd_data,
  output logic                                  rd_valid,
  input  logic                                  clear_req,
  output logic                                  busy,
  output logic [$clog2(BOARD_DIM*BOARD_DIM+1)-1:0] stone_count,
  output logic [BOARD_DIM*BOARD_DIM*CELL_W-1:0] board_out
);

  localparam int CNT_W = $clog2(BOARD_DIM*BOARD_DIM+1);
  localparam logic [XY_W-1:0] LAST_ROW = XY_W'(BOARD_DIM-1);
  localparam logic [XY_W:0]   DIM_V    = (XY_W+1)'(BOARD_DIM);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [XY_W-1:0]   row_q, row_d;

  // x is the outer packed dimension so the flattened vector matches board_out
  logic [BOARD_DIM-1:0][BOARD_DIM-1:0][CELL_W-1:0] cells_q, cells_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CELL_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;

  logic              wr_go, rd_go, sweep, sweep_last;
  logic [XY_W-1:0]   wr_x, wr_y, rd_x, rd_y;
  logic              wr_in_rng, wr_occ, wr_commit, wr_reject;
  logic [CELL_W-1:0] wr_old, rd_val;

  assign wr_x = wr_addr[2*XY_W-1:XY_W];
  assign wr_y = wr_addr[XY_W-1:0];
  assign rd_x = rd_addr[2*XY_W-1:XY_W];
  assign rd_y = rd_addr[XY_W-1:0];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // clear_req is only looked at in IDLE, so a request mid-sweep cannot restart it
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          row_d   = '0;
        end
      end
      S_CLEAR: begin
        row_d = row_q + 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = S_IDLE;
          row_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Clear wins over a same-cycle write; reads in IDLE are still served.
  always_comb begin
    sweep      = (state_q == S_CLEAR);
    sweep_last = sweep && (row_q == LAST_ROW);
    busy       = sweep;
    wr_go      = (state_q == S_IDLE) && wr_en && !clear_req;
    rd_go      = (state_q == S_IDLE) && rd_en;
  end

  // ---------------- cell lookup ----------------
  // Out-of-range coordinates match no cell, so they read back as 0.
  always_comb begin
    wr_old = '0;
    rd_val = '0;
    for (int x = 0; x < BOARD_DIM; x++) begin
      for (int y = 0; y < BOARD_DIM; y++) begin
        if (wr_x == XY_W'(x) && wr_y == XY_W'(y)) wr_old = cells_q[x][y];
        if (rd_x == XY_W'(x) && rd_y == XY_W'(y)) rd_val = cells_q[x][y];
      end
    end
  end

  always_comb begin
    wr_in_rng = ({1'b0, wr_x} < DIM_V) && ({1'b0, wr_y} < DIM_V);
`ifdef BOARD_MEM_OCCUPY_CHECK_EN
    wr_occ    = (wr_old != '0) && (wr_data != '0);
`else
    wr_occ    = 1'b0;
`endif
    wr_commit = wr_go && wr_in_rng && !wr_occ;
    wr_reject = wr_go && (!wr_in_rng || wr_occ);
  end

  // ---------------- next-state datapath ----------------
  always_comb begin
    cells_d = cells_q;
    for (int x = 0; x < BOARD_DIM; x++) begin
      for (int y = 0; y < BOARD_DIM; y++) begin
        if (sweep && row_q == XY_W'(x))
          cells_d[x][y] = '0;
        else if (wr_commit && wr_x == XY_W'(x) && wr_y == XY_W'(y))
          cells_d[x][y] = wr_data;
      end
    end
  end

  // Count tracks empty<->occupied transitions only; the sweep zeroes it on its
  // last row, when every row has been wiped.
  always_comb begin
    cnt_d = cnt_q;
    if (sweep_last)
      cnt_d = '0;
    else if (wr_commit) begin
      if (wr_old == '0 && wr_data != '0)      cnt_d = cnt_q + 1'b1;
      else if (wr_old != '0 && wr_data == '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // rd_val comes from cells_q, so a same-cycle write is not visible (read-before-write)
  always_comb begin
    rd_valid_d = rd_go;
    rd_data_d  = rd_go ? rd_val : rd_data_q;
    wr_ack_d   = wr_commit;
    wr_err_d   = wr_reject;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cells_q    <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      cells_q    <= cells_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign wr_err      = wr_err_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign stone_count = cnt_q;
  assign board_out   = cells_q;

endmodule

// File: tb/tb_board_mem_rw.sv
// Self-checking bench for board_mem_rw: behavioural board model, read
// scoreboard queue, per-cycle checks of pulses, busy, count and board.
module tb_board_mem_rw;
  localparam int BD    = 16;
  localparam int XW    = 5;   // wide enough to express x=16 out of range
  localparam int CW    = 2;
  localparam int NB    = BD*BD*CW;
  localparam int CNT_W = $clog2(BD*BD+1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0, rd_en = 1'b0, clear_req = 1'b0;
  logic [2*XW-1:0]   wr_addr = '0, rd_addr = '0;
  logic [CW-1:0]     wr_data = '0;
  logic              wr_ack, wr_err, rd_valid, busy;
  logic [CW-1:0]     rd_data;
  logic [CNT_W-1:0]  stone_count;
  logic [NB-1:0]     board_out;

  board_mem_rw #(.BOARD_DIM(BD), .XY_W(XW), .CELL_W(CW)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clear_req(clear_req), .busy(busy),
    .stone_count(stone_count), .board_out(board_out)
  );

  always #5 clock = ~clock;

  int mdl [BD][BD];
  int mcnt, mbusy, last_rd;
  int rd_q [$];
  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_board();
    logic [NB-1:0] b;
    b = '0;
    for (int x = 0; x < BD; x++)
      for (int y = 0; y < BD; y++)
        b[(x*BD+y)*CW +: CW] = CW'(mdl[x][y]);
    return b;
  endfunction

  task automatic mdl_clear();
    for (int x = 0; x < BD; x++)
      for (int y = 0; y < BD; y++)
        mdl[x][y] = 0;
    mcnt = 0;
  endtask

  // One clock cycle: drive at negedge, update model, check after the posedge.
  task automatic cyc(input bit we, input int wx, input int wy, input int wd,
                     input bit re, input int rx, input int ry, input bit clr);
    bit idle, e_ack, e_err, e_rv;
    int v;
    @(negedge clock);
    wr_en = we; wr_addr = {XW'(wx), XW'(wy)}; wr_data = CW'(wd);
    rd_en = re; rd_addr = {XW'(rx), XW'(ry)}; clear_req = clr;
    idle = (mbusy == 0);
    e_ack = 1'b0; e_err = 1'b0;
    e_rv = idle && re;
    if (e_rv) rd_q.push_back((rx < BD && ry < BD) ? mdl[rx][ry] : 0);
    if (!idle) begin
      mbusy--;
      if (mbusy == 0) mdl_clear();
    end else if (clr) begin
      mbusy = BD;
    end else if (we) begin
      if (wx >= BD || wy >= BD) e_err = 1'b1;
`ifdef BOARD_MEM_OCCUPY_CHECK_EN
      else if (mdl[wx][wy] != 0 && wd != 0) e_err = 1'b1;
`endif
      else begin
        e_ack = 1'b1;
        if (mdl[wx][wy] == 0 && wd != 0) mcnt++;
        else if (mdl[wx][wy] != 0 && wd == 0) mcnt--;
        mdl[wx][wy] = wd;
      end
    end
    @(posedge clock); #1;
    chk("wr_ack", wr_ack, e_ack);
    chk("wr_err", wr_err, e_err);
    chk("rd_valid", rd_valid, e_rv);
    chk("busy", busy, mbusy > 0);
    if (rd_valid && rd_q.size() > 0) begin
      v = rd_q.pop_front();
      chk("rd_data", rd_data, v);
      last_rd = v;
    end else if (!rd_valid) begin
      chk("rd_hold", rd_data, last_rd);
    end
    if (mbusy == 0) begin
      chk("stone_count", stone_count, mcnt);
      chk("board_out", board_out, exp_board());
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    @(posedge clock); #1;
    chk("rst_busy", busy, 0);
    chk("rst_count", stone_count, 0);
    chk("rst_board", board_out, 0);
    chk("rst_ack", wr_ack, 0);
    chk("rst_err", wr_err, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    mdl_clear();
    mbusy = 0; last_rd = 0;
    rd_q.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    mdl_clear(); mbusy = 0; last_rd = 0;
    do_reset();

    // basic write, then read back
    cyc(1, 3, 5, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3, 5, 0);
    nop(1);

    // same-cycle read/write returns pre-write value, later read sees new value
    cyc(1, 7, 7, 1, 1, 7, 7, 0);
    cyc(0, 0, 0, 0, 1, 7, 7, 0);

    // out-of-range writes and read
    cyc(1, 16, 0, 3, 0, 0, 0, 0);
    cyc(1, 2, 20, 1, 1, 16, 3, 0);

    // occupied-cell write, then write zero to free cells
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 3, 5, 0, 0, 0, 0, 0);
    cyc(1, 4, 4, 0, 0, 0, 0, 0);

    // fill 10 cells, clear with a colliding write, hammer ports during sweep
    for (int i = 0; i < 10; i++) cyc(1, i + 5, (i * 3) % BD, (i % 3) + 1, 1, i, i, 0);
    cyc(1, 9, 9, 1, 0, 0, 0, 1);
    for (int i = 0; i < BD; i++) cyc(1, i, i, 1, 1, i, i, i == 3);
    nop(2);

    // random traffic with occasional clears
    for (int i = 0; i < 80; i++)
      cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 17)), int'($urandom_range(0, 17)),
          int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 17)), int'($urandom_range(0, 17)), $urandom_range(0, 19) == 0);
    nop(BD + 2);

    // reset in the middle of a sweep
    for (int i = 0; i < 4; i++) cyc(1, i, 15 - i, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    nop(5);
    do_reset();
    cyc(1, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 1, 0);
    nop(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
